// File: rtl/tcm_stream_reader.sv
// Reads a burst of words from the 32-entry TCM and streams them out as one AXI-Stream packet.
// Reads are throttled so buffered plus outstanding words never exceed the 2-entry output FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a start edge on USR_tcm_control[0]
// S_RUN   | issuing TCM reads until the whole burst has been requested
// S_DRAIN | all reads issued; streaming the remaining words until TLAST
module tcm_stream_reader #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH         = 2
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESET,
    input  logic [31:0]                     USR_tcm_control,
    output logic                            tcm_rd_en,
    output logic [4:0]                      tcm_rd_addr,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] tcm_rd_data,
    output logic                            M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [2:0] L_DEPTH = 3'(C_FIFO_DEPTH);

    state_t                          r_state;
    logic                            r_start_q;
    logic [4:0]                      r_addr;
    logic [5:0]                      r_len;
    logic [5:0]                      r_issued;
    logic [5:0]                      r_sent;
    logic                            r_rd_en;
    logic [4:0]                      r_rd_addr;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_pend;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] r_mem [0:1];
    logic                            r_wr_ptr;
    logic                            r_rd_ptr;
    logic [1:0]                      r_count;

    logic       w_start;
    logic       w_pop;
    logic       w_push;
    logic [2:0] w_occ;
    logic       w_issue;
    logic       w_last_beat;
    logic       w_unused_ctrl;

    assign w_unused_ctrl = ^{USR_tcm_control[31:21], USR_tcm_control[15:13], USR_tcm_control[7:1]};

    assign w_start     = USR_tcm_control[0] & ~r_start_q;
    assign w_pop       = M_AXIS_TVALID & M_AXIS_TREADY;
    assign w_push      = r_pend;
    // Occupancy covers words buffered, strobes on the bus and data returning next edge.
    assign w_occ       = {1'b0, r_count} + {2'b00, r_rd_en} + {2'b00, r_pend};
    assign w_issue     = (r_state == S_RUN) && (r_issued < r_len) &&
                         (w_occ < (L_DEPTH + {2'b00, w_pop}));
    assign w_last_beat = w_pop && (r_sent == r_len - 6'd1);

    assign M_AXIS_TVALID = (r_count != 2'd0);
    assign M_AXIS_TDATA  = r_mem[r_rd_ptr];
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (r_sent == r_len - 6'd1);
    assign tcm_rd_en     = r_rd_en;
    assign tcm_rd_addr   = r_rd_addr;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_addr    <= 5'd0;
            r_len     <= 6'd0;
            r_issued  <= 6'd0;
            r_sent    <= 6'd0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= USR_tcm_control[0];
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            if (w_pop) begin
                r_sent <= r_sent + 6'd1;
            end
            if (w_issue) begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= r_addr;
                r_addr    <= r_addr + 5'd1;
                r_issued  <= r_issued + 6'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr   <= USR_tcm_control[12:8];
                        r_len    <= {1'b0, USR_tcm_control[20:16]} + 6'd1;
                        r_issued <= 6'd0;
                        r_sent   <= 6'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_issued == r_len) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_beat) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset clears r_pend, so a TCM word returning after reset is dropped.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_pend   <= 1'b0;
        end else begin
            r_pend <= r_rd_en;
            if (w_push) begin
                r_mem[r_wr_ptr] <= tcm_rd_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_tcm_stream_reader.sv
// Bench for tcm_stream_reader: registered TCM model, table-driven bursts, reset-mid-burst
// sequence and randomized bursts compared against an expected-packet queue.
module tb_tcm_stream_reader;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl;
    logic        tcm_rd_en;
    logic [4:0]  tcm_rd_addr;
    logic [31:0] tcm_rd_data;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic        done;

    logic [31:0] tcm [0:31];
    int checks;
    int failures;

    tcm_stream_reader #(
        .C_M_AXIS_TDATA_WIDTH(32),
        .C_FIFO_DEPTH(2)
    ) dut (
        .M_AXIS_ACLK     (clk),
        .M_AXIS_ARESET   (rst),
        .USR_tcm_control (ctrl),
        .tcm_rd_en       (tcm_rd_en),
        .tcm_rd_addr     (tcm_rd_addr),
        .tcm_rd_data     (tcm_rd_data),
        .M_AXIS_TVALID   (tvalid),
        .M_AXIS_TDATA    (tdata),
        .M_AXIS_TLAST    (tlast),
        .M_AXIS_TREADY   (tready),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read TCM: data appears the cycle after the strobe is sampled.
    always @(posedge clk) begin
        if (tcm_rd_en) tcm_rd_data <= tcm[tcm_rd_addr];
    end

    typedef struct {
        int          addr;
        int          lenm1;
        int          rmode;
        int          mid;
        bit          hold;
        logic [31:0] first;
        logic [31:0] lastw;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] make_ctrl(input int addr, input int lenm1, input logic s);
        logic [4:0] a;
        logic [4:0] l;
        a = 5'(addr);
        l = 5'(lenm1);
        return {11'd0, l, 3'd0, a, 7'd0, s};
    endfunction

    task automatic fill_pattern();
        for (int i = 0; i < 32; i++) tcm[i] = 32'hA000_0000 + 32'(i);
    endtask

    task automatic run_burst(input int addr, input int lenm1, input int rmode, input int mid,
                             input bit hold, input logic [31:0] exp_first, input logic [31:0] exp_lastw);
        logic [31:0] exp_q [$];
        logic [31:0] held_data;
        logic        held_last;
        logic [3:0]  pat;
        bit          stalled;
        bit          rdy;
        int          n, k, beats, nstr, first_str, first_val;
        n = lenm1 + 1;
        pat = 4'b1001;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(tcm[(addr + i) % 32]);
        stalled = 0; held_data = '0; held_last = 0;
        k = 0; beats = 0; nstr = 0; first_str = -1; first_val = -1;
        @(negedge clk);
        ctrl = make_ctrl(addr, lenm1, 1'b1);
        @(posedge clk);
        while (beats < n && k < 600) begin
            @(negedge clk);
            if (!hold && k == 2) ctrl[0] = 1'b0;
            if (mid > 0 && k == mid) ctrl = make_ctrl((addr + 11) % 32, (lenm1 + 3) % 32, 1'b1);
            if (mid > 0 && k == mid + 2) ctrl[0] = 1'b0;
            if (k == 0) begin
                check("busy_after_start", {31'd0, busy}, 32'd1);
                check("rd_en_at_c0", {31'd0, tcm_rd_en}, 32'd0);
            end
            if (tcm_rd_en) begin
                if (first_str < 0) first_str = k;
                check("rd_addr", {27'd0, tcm_rd_addr}, 32'((addr + nstr) % 32));
                nstr++;
            end
            check("occupancy_le2", {31'd0, (nstr - beats) <= 2}, 32'd1);
            if (tvalid && first_val < 0) first_val = k;
            if (done) check("done_during_burst", {31'd0, done}, 32'd0);
            if (stalled) begin
                check("tvalid_held", {31'd0, tvalid}, 32'd1);
                check("tdata_stable", tdata, held_data);
                check("tlast_stable", {31'd0, tlast}, {31'd0, held_last});
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = pat[k % 4];
            endcase
            tready = rdy;
            if (tvalid && rdy) begin
                check("beat_data", tdata, exp_q[beats]);
                check("beat_tlast", {31'd0, tlast}, {31'd0, beats == n - 1});
                if (beats == 0) check("first_word", tdata, exp_first);
                if (beats == n - 1) check("last_word", tdata, exp_lastw);
                beats++;
                stalled = 0;
            end else begin
                stalled = tvalid;
                held_data = tdata;
                held_last = tlast;
            end
            k++;
        end
        check("burst_complete", 32'(beats), 32'(n));
        check("first_strobe_cycle", 32'(first_str), 32'd1);
        check("first_tvalid_cycle", 32'(first_val), 32'd3);
        check("strobe_count", 32'(nstr), 32'(n));
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("tvalid_after_last", {31'd0, tvalid}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        if (hold) begin
            repeat (4) @(negedge clk);
            check("held_start_no_retrigger", {30'd0, busy, tcm_rd_en}, 32'd0);
            ctrl[0] = 1'b0;
        end
    endtask

    initial begin
        int k;
        int beats;
        bit quiet;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        ctrl = '0;
        tready = 1'b0;
        fill_pattern();

        repeat (3) @(negedge clk);
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tlast", {31'd0, tlast}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_rd_en", {31'd0, tcm_rd_en}, 32'd0);
        check("rst_rd_addr", {27'd0, tcm_rd_addr}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs[0] = '{4, 7, 0, 0, 1'b0, 32'hA000_0004, 32'hA000_000B};
        vecs[1] = '{30, 3, 0, 0, 1'b0, 32'hA000_001E, 32'hA000_0001};
        vecs[2] = '{0, 31, 2, 0, 1'b0, 32'hA000_0000, 32'hA000_001F};
        vecs[3] = '{5, 31, 1, 0, 1'b0, 32'hA000_0005, 32'hA000_0004};
        vecs[4] = '{17, 0, 0, 0, 1'b0, 32'hA000_0011, 32'hA000_0011};
        vecs[5] = '{8, 15, 0, 6, 1'b0, 32'hA000_0008, 32'hA000_0017};
        vecs[6] = '{12, 2, 1, 0, 1'b1, 32'hA000_000C, 32'hA000_000E};
        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].addr, vecs[v].lenm1, vecs[v].rmode, vecs[v].mid,
                      vecs[v].hold, vecs[v].first, vecs[v].lastw);
        end

        // Reset in the middle of a 16-word burst, then a fresh burst from another address.
        @(negedge clk);
        ctrl = make_ctrl(9, 15, 1'b1);
        tready = 1'b1;
        beats = 0;
        k = 0;
        while (beats < 5 && k < 200) begin
            @(negedge clk);
            if (k == 2) ctrl[0] = 1'b0;
            if (tvalid) begin
                check("pre_reset_data", tdata, 32'hA000_0009 + 32'(beats));
                beats++;
            end
            k++;
        end
        check("pre_reset_beats", 32'(beats), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rd_en", {31'd0, tcm_rd_en}, 32'd0);
        rst = 1'b0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (tvalid || busy || tcm_rd_en) quiet = 0;
        end
        check("post_rst_quiet", {31'd0, quiet}, 32'd1);
        run_burst(20, 5, 0, 0, 1'b0, 32'hA000_0014, 32'hA000_0019);

        for (int r = 0; r < 6; r++) begin
            int ra, rl, rm;
            for (int i = 0; i < 32; i++) tcm[i] = $urandom;
            ra = $urandom_range(0, 31);
            rl = $urandom_range(0, 31);
            rm = $urandom_range(0, 2);
            run_burst(ra, rl, rm, 0, 1'b0, tcm[ra], tcm[(ra + rl) % 32]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
